multi_alarm_clock: RTL

- 24-hour BCD timekeeper with NUM_ALARMS independent alarms.
- Includes key debounce, a mode state machine (run / set time / set alarm k) and a ring/snooze state machine driving a square-wave buzzer.
- Sits between board keys/switches and the 7-segment display driver. Display digits are muxed by mode.

---
 rtl/multi_alarm_clock.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module   : multi_alarm_clock
//  Purpose  : 24-hour BCD timekeeper with NUM_ALARMS alarms, key debounce,
//             run/set mode sequencing, ring/snooze control and buzzer tone.
//  Revision : 1.0  initial release
// ============================================================================
module multi_alarm_clock #(
    parameter int CLK_HZ          = 50000000,
    parameter int NUM_ALARMS      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BUZZ_HALF       = 25000,
    parameter int RING_SEC        = 60,
    parameter int SNOOZE_MIN      = 5,
    localparam int MW = $clog2(NUM_ALARMS + 2),
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  MODE_KEY_N,
    input  logic                  SET_KEY_N,
    input  logic [7:0]            SET_IN,
    input  logic                  FIELD_SEL,
    input  logic [NUM_ALARMS-1:0] ALARM_EN,
    output logic [3:0]            HOUR_TEN,
    output logic [3:0]            HOUR_ONE,
    output logic [3:0]            MIN_TEN,
    output logic [3:0]            MIN_ONE,
    output logic [3:0]            SEC_TEN,
    output logic [3:0]            SEC_ONE,
    output logic [MW-1:0]         MODE,
    output logic                  RINGING,
    output logic                  SNOOZING,
    output logic [AW-1:0]         ALARM_ACTIVE,
    output logic                  BUZZER
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int BW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF + 1) : 1;
    localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC + 1) : 1;
    localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);

    localparam logic [PW-1:0] C_PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] C_DEB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] C_BUZZ_LAST  = BW'(BUZZ_HALF - 1);
    localparam logic [RW-1:0] C_RING_LAST  = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] C_SNZ_LOAD   = SW'(SNOOZE_MIN * 60);
    localparam logic [MW-1:0] C_MODE_RUN   = MW'(0);
    localparam logic [MW-1:0] C_MODE_STIME = MW'(1);
    localparam logic [MW-1:0] C_MODE_LAST  = MW'(NUM_ALARMS + 1);

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_RING   = 2'd1,
        RS_SNOOZE = 2'd2
    } ring_state_t;

    // ------------------------------------------------------------------
    // Key synchronisation and debounce (bit 0 = MODE, bit 1 = SET)
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_fall;
    logic       w_mode_press;
    logic       w_set_press;

    assign w_raw = {SET_KEY_N, MODE_KEY_N};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_key
            logic          r_sync1;
            logic          r_sync2;
            logic          r_deb;
            logic [DW-1:0] r_cnt;

            // Two-stage synchroniser, then accept a new level once it has
            // differed from the debounced level for DEBOUNCE_CYCLES samples.
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_deb   <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[g];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_DEB_MAX) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Press pulse coincides with the cycle the debounced level falls.
            assign w_fall[g] = r_deb & ~r_sync2 & (r_cnt == C_DEB_MAX);
        end
    endgenerate

    // A simultaneous MODE press wins; the SET press is dropped.
    assign w_mode_press = w_fall[0];
    assign w_set_press  = w_fall[1] & ~w_fall[0];

    // ------------------------------------------------------------------
    // Mode decode
    // ------------------------------------------------------------------
    logic [MW-1:0] r_mode;
    logic [MW-1:0] w_mode_next;
    logic          w_in_run;
    logic          w_in_set_time;
    logic          w_in_set_alarm;
    logic [AW-1:0] w_alarm_sel;
    ring_state_t   r_state;
    ring_state_t   w_state_next;

    assign w_in_run       = (r_mode == C_MODE_RUN);
    assign w_in_set_time  = (r_mode == C_MODE_STIME);
    assign w_in_set_alarm = !w_in_run && !w_in_set_time;
    assign w_alarm_sel    = AW'(r_mode - MW'(2));

    // Mode next-state: advance on MODE press unless the press is used to
    // dismiss an active ring.
    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_press && (r_state == RS_IDLE)) begin
            if (r_mode == C_MODE_LAST) begin
                w_mode_next = C_MODE_RUN;
            end else begin
                w_mode_next = r_mode + 1'b1;
            end
        end
    end

    // Mode state register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mode <= C_MODE_RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // ------------------------------------------------------------------
    // Seconds prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic          w_sec_tick;

    assign w_sec_tick = !w_in_set_time && (r_presc == C_PRESC_MAX);

    // Free-running divider, parked at zero while the time is being set.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if (w_in_set_time || (r_presc == C_PRESC_MAX)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Set-value validation
    // ------------------------------------------------------------------
    logic w_min_ok;
    logic w_hour_ok;
    logic w_field_ok;

    assign w_min_ok   = (SET_IN[7:4] <= 4'd5) && (SET_IN[3:0] <= 4'd9);
    assign w_hour_ok  = (SET_IN[7:4] <= 4'd2) && (SET_IN[3:0] <= 4'd9) &&
                        !((SET_IN[7:4] == 4'd2) && (SET_IN[3:0] > 4'd3));
    assign w_field_ok = FIELD_SEL ? w_hour_ok : w_min_ok;

    // ------------------------------------------------------------------
    // Time of day
    // ------------------------------------------------------------------
    logic [3:0] r_hour_ten, r_hour_one, r_min_ten, r_min_one, r_sec_ten, r_sec_one;
    logic [3:0] w_hour_ten, w_hour_one, w_min_ten, w_min_one, w_sec_ten, w_sec_one;
    logic [15:0] w_inc_hhmm;
    logic        w_inc_sec_zero;

    // BCD increment of the current time by one second with cascaded carries.
    always_comb begin
        w_hour_ten = r_hour_ten;
        w_hour_one = r_hour_one;
        w_min_ten  = r_min_ten;
        w_min_one  = r_min_one;
        w_sec_ten  = r_sec_ten;
        w_sec_one  = r_sec_one;
        if (r_sec_one != 4'd9) begin
            w_sec_one = r_sec_one + 4'd1;
        end else begin
            w_sec_one = 4'd0;
            if (r_sec_ten != 4'd5) begin
                w_sec_ten = r_sec_ten + 4'd1;
            end else begin
                w_sec_ten = 4'd0;
                if (r_min_one != 4'd9) begin
                    w_min_one = r_min_one + 4'd1;
                end else begin
                    w_min_one = 4'd0;
                    if (r_min_ten != 4'd5) begin
                        w_min_ten = r_min_ten + 4'd1;
                    end else begin
                        w_min_ten = 4'd0;
                        if ((r_hour_ten == 4'd2) && (r_hour_one == 4'd3)) begin
                            w_hour_ten = 4'd0;
                            w_hour_one = 4'd0;
                        end else if (r_hour_one == 4'd9) begin
                            w_hour_one = 4'd0;
                            w_hour_ten = r_hour_ten + 4'd1;
                        end else begin
                            w_hour_one = r_hour_one + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign w_inc_hhmm     = {w_hour_ten, w_hour_one, w_min_ten, w_min_one};
    assign w_inc_sec_zero = (w_sec_ten == 4'd0) && (w_sec_one == 4'd0);

    // Time register: loads in SET_TIME (seconds held at zero), counts otherwise.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hour_ten <= 4'd0;
            r_hour_one <= 4'd0;
            r_min_ten  <= 4'd0;
            r_min_one  <= 4'd0;
            r_sec_ten  <= 4'd0;
            r_sec_one  <= 4'd0;
        end else if (w_in_set_time) begin
            r_sec_ten <= 4'd0;
            r_sec_one <= 4'd0;
            if (w_set_press && w_field_ok) begin
                if (FIELD_SEL) begin
                    {r_hour_ten, r_hour_one} <= SET_IN;
                end else begin
                    {r_min_ten, r_min_one} <= SET_IN;
                end
            end
        end else if (w_sec_tick) begin
            r_hour_ten <= w_hour_ten;
            r_hour_one <= w_hour_one;
            r_min_ten  <= w_min_ten;
            r_min_one  <= w_min_one;
            r_sec_ten  <= w_sec_ten;
            r_sec_one  <= w_sec_one;
        end
    end

    // ------------------------------------------------------------------
    // Alarm registers ({HH, MM} in BCD)
    // ------------------------------------------------------------------
    logic [15:0] r_alarm [NUM_ALARMS];

    // Alarm k is written only while its own set mode is selected.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                r_alarm[k] <= 16'h0000;
            end
        end else if (w_in_set_alarm && w_set_press && w_field_ok) begin
            if (FIELD_SEL) begin
                r_alarm[w_alarm_sel][15:8] <= SET_IN;
            end else begin
                r_alarm[w_alarm_sel][7:0] <= SET_IN;
            end
        end
    end

    // Lowest-index enabled alarm equal to the upcoming HH:MM.
    logic          w_match;
    logic [AW-1:0] w_match_idx;
    logic          w_ring_start;

    // Scan downwards so the lowest matching index is the one kept.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (ALARM_EN[k] && (r_alarm[k] == w_inc_hhmm)) begin
                w_match     = 1'b1;
                w_match_idx = AW'(k);
            end
        end
    end

    assign w_ring_start = w_match && w_sec_tick && w_in_run && w_inc_sec_zero;

    // ------------------------------------------------------------------
    // Ring / snooze state machine
    // ------------------------------------------------------------------
    logic [RW-1:0] r_ring_cnt, w_ring_cnt;
    logic [SW-1:0] r_snz_cnt,  w_snz_cnt;
    logic [BW-1:0] r_buzz_cnt, w_buzz_cnt;
    logic          r_buzz,     w_buzz;
    logic [AW-1:0] r_active,   w_active;
    logic          w_dismiss;

    assign w_dismiss = w_mode_press || !ALARM_EN[r_active] || !w_in_run;

    // Ring next-state and counters; dismiss beats snooze beats timeout.
    always_comb begin
        w_state_next = r_state;
        w_ring_cnt   = r_ring_cnt;
        w_snz_cnt    = r_snz_cnt;
        w_buzz_cnt   = r_buzz_cnt;
        w_buzz       = 1'b0;
        w_active     = r_active;
        case (r_state)
            RS_IDLE: begin
                if (w_ring_start) begin
                    w_state_next = RS_RING;
                    w_active     = w_match_idx;
                    w_ring_cnt   = '0;
                    w_buzz_cnt   = '0;
                end
            end
            RS_RING: begin
                if (w_dismiss) begin
                    w_state_next = RS_IDLE;
                end else if (w_set_press) begin
                    w_state_next = RS_SNOOZE;
                    w_snz_cnt    = C_SNZ_LOAD;
                end else if (w_sec_tick && (r_ring_cnt == C_RING_LAST)) begin
                    w_state_next = RS_IDLE;
                end else begin
                    if (w_sec_tick) begin
                        w_ring_cnt = r_ring_cnt + 1'b1;
                    end
                    if (r_buzz_cnt == C_BUZZ_LAST) begin
                        w_buzz_cnt = '0;
                        w_buzz     = ~r_buzz;
                    end else begin
                        w_buzz_cnt = r_buzz_cnt + 1'b1;
                        w_buzz     = r_buzz;
                    end
                end
            end
            RS_SNOOZE: begin
                if (w_dismiss) begin
                    w_state_next = RS_IDLE;
                end else if (w_sec_tick) begin
                    if (r_snz_cnt <= SW'(1)) begin
                        w_state_next = RS_RING;
                        w_snz_cnt    = '0;
                        w_ring_cnt   = '0;
                        w_buzz_cnt   = '0;
                    end else begin
                        w_snz_cnt = r_snz_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = RS_IDLE;
            end
        endcase
    end

    // Ring state register and associated counters
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= RS_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_buzz_cnt <= '0;
            r_buzz     <= 1'b0;
            r_active   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ring_cnt <= w_ring_cnt;
            r_snz_cnt  <= w_snz_cnt;
            r_buzz_cnt <= w_buzz_cnt;
            r_buzz     <= w_buzz;
            r_active   <= w_active;
        end
    end

    // ------------------------------------------------------------------
    // Display mux (registered)
    // ------------------------------------------------------------------
    // Alarm modes show the selected alarm with zero seconds; else live time.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            HOUR_TEN <= 4'd0;
            HOUR_ONE <= 4'd0;
            MIN_TEN  <= 4'd0;
            MIN_ONE  <= 4'd0;
            SEC_TEN  <= 4'd0;
            SEC_ONE  <= 4'd0;
        end else if (w_in_set_alarm) begin
            {HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE} <= r_alarm[w_alarm_sel];
            SEC_TEN <= 4'd0;
            SEC_ONE <= 4'd0;
        end else begin
            HOUR_TEN <= r_hour_ten;
            HOUR_ONE <= r_hour_one;
            MIN_TEN  <= r_min_ten;
            MIN_ONE  <= r_min_one;
            SEC_TEN  <= r_sec_ten;
            SEC_ONE  <= r_sec_one;
        end
    end

    assign MODE         = r_mode;
    assign RINGING      = (r_state == RS_RING);
    assign SNOOZING     = (r_state == RS_SNOOZE);
    assign ALARM_ACTIVE = r_active;
    assign BUZZER       = r_buzz;

endmodule
`default_nettype wire
